memory_stage: RTL and testbench

- MEM pipeline stage plus MEM/WB pipeline register; sits directly upstream of the writeback stage.
- Drives the data-memory port with a req/ack handshake that supports wait states. Stalls upstream stages while an access is outstanding.
- Registers the 2-bit writeback control, ALU result, memory read data and destination register for WB.

---
 rtl/memory_stage.sv | 146 ++++++++++++++
 tb/tb_memory_stage.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// memory_stage: MEM pipeline stage plus the MEM/WB pipeline register.
//
// This stage drives the data-memory port using a req/ack handshake, and the
// memory may insert wait states. While an access is outstanding the stage
// stalls the upstream stages and sends bubbles into WB. An instruction
// reaches WB only after it has retired.
//
// Optional feature (compile-time macro DMEM_TIMEOUT_EN):
//   Adds a watchdog on the WAIT state. If no ack arrives within
//   TIMEOUT_CYCLES cycles, the access is dropped and mem_fault pulses for
//   one cycle.
//
// Ports:
//   clk, reset       rising-edge clock; asynchronous active-high reset
//   control_m        {reg_we, sel_reg_write_data, mem_we} of the MEM instr
//   alu_result_m     ALU result / memory byte address
//   write_data_m     store data
//   write_reg_m      destination register index
//   stall_m          1 = hold IF/ID/EX/MEM inputs this cycle
//   dmem_req/we/addr/wdata/rdata/ack   data-memory handshake port
//   control_w, alu_result_w, mem_read_data_w, write_reg_w   MEM/WB register
//   mem_fault        one-cycle timeout pulse (DMEM_TIMEOUT_EN only)
module memory_stage #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [2:0]                control_m,
  input  logic [31:0]               alu_result_m,
  input  logic [31:0]               write_data_m,
  input  logic [REG_ADDR_WIDTH-1:0] write_reg_m,
  output logic                      stall_m,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [31:0]               dmem_addr,
  output logic [31:0]               dmem_wdata,
  input  logic [31:0]               dmem_rdata,
  input  logic                      dmem_ack,
  output logic [1:0]                control_w,
  output logic [31:0]               alu_result_w,
  output logic [31:0]               mem_read_data_w,
`ifdef DMEM_TIMEOUT_EN
  output logic                      mem_fault,
`endif
  output logic [REG_ADDR_WIDTH-1:0] write_reg_w
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("memory_stage: TIMEOUT_CYCLES out of range 1..65535");
  end

  typedef enum logic { IDLE = 1'b0, WAIT = 1'b1 } state_t;

  state_t                    state_q, state_d;
  logic [1:0]                control_w_q, control_w_d;
  logic [31:0]               alu_result_w_q, alu_result_w_d;
  logic [31:0]               mem_read_data_w_q, mem_read_data_w_d;
  logic [REG_ADDR_WIDTH-1:0] write_reg_w_q, write_reg_w_d;

  logic is_load, is_store, is_access;
  logic timeout;
  logic retire;

  // A store wins whenever mem_we is set, even if the load select is also set.
  assign is_store  = control_m[0];
  assign is_load   = control_m[1] & ~control_m[0];
  assign is_access = is_load | is_store;

  assign dmem_we    = is_store;
  assign dmem_addr  = {alu_result_m[31:2], 2'b00};
  assign dmem_wdata = write_data_m;

`ifdef DMEM_TIMEOUT_EN
  logic [15:0] tmo_cnt_q, tmo_cnt_d;

  assign timeout   = (state_q == WAIT) & ~dmem_ack & (tmo_cnt_q == 16'(TIMEOUT_CYCLES));
  assign mem_fault = timeout & ~reset;

  // The counter stays at zero in IDLE, so it is already clear on entry to WAIT.
  always_comb begin
    tmo_cnt_d = 16'd0;
    if (state_q == WAIT && !dmem_ack) tmo_cnt_d = tmo_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tmo_cnt_q <= 16'd0;
    else       tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  // The request is held for the whole WAIT state. Upstream is frozen during
  // WAIT, so the M inputs still describe the same access.
  assign dmem_req = ~reset & ((state_q == WAIT) | is_access);
  assign stall_m  = dmem_req & ~dmem_ack & ~timeout;

  // An instruction retires when it is a non-access op, or when its access
  // has been acked. Every other cycle sends a bubble into WB.
  assign retire = ((state_q == IDLE) & ~is_access) | (dmem_req & dmem_ack);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (is_access && !dmem_ack) state_d = WAIT;
      WAIT:    if (dmem_ack || timeout)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    control_w_d       = 2'b00;
    alu_result_w_d    = alu_result_w_q;
    mem_read_data_w_d = mem_read_data_w_q;
    write_reg_w_d     = write_reg_w_q;
    if (retire) begin
      control_w_d       = control_m[2:1];
      alu_result_w_d    = alu_result_m;
      write_reg_w_d     = write_reg_m;
      mem_read_data_w_d = (is_load && dmem_ack) ? dmem_rdata : 32'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= IDLE;
      control_w_q       <= 2'b00;
      alu_result_w_q    <= 32'd0;
      mem_read_data_w_q <= 32'd0;
      write_reg_w_q     <= '0;
    end else begin
      state_q           <= state_d;
      control_w_q       <= control_w_d;
      alu_result_w_q    <= alu_result_w_d;
      mem_read_data_w_q <= mem_read_data_w_d;
      write_reg_w_q     <= write_reg_w_d;
    end
  end

  assign control_w       = control_w_q;
  assign alu_result_w    = alu_result_w_q;
  assign mem_read_data_w = mem_read_data_w_q;
  assign write_reg_w     = write_reg_w_q;

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  control_m;
  logic [31:0] alu_result_m, write_data_m, dmem_rdata;
  logic [4:0]  write_reg_m;
  logic        dmem_ack;
  logic        stall_m, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [1:0]  control_w;
  logic [31:0] alu_result_w, mem_read_data_w;
  logic [4:0]  write_reg_w;
`ifdef DMEM_TIMEOUT_EN
  logic        mem_fault;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  memory_stage #(.REG_ADDR_WIDTH(5), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .control_m(control_m), .alu_result_m(alu_result_m),
    .write_data_m(write_data_m), .write_reg_m(write_reg_m), .stall_m(stall_m),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .control_w(control_w), .alu_result_w(alu_result_w),
    .mem_read_data_w(mem_read_data_w),
`ifdef DMEM_TIMEOUT_EN
    .mem_fault(mem_fault),
`endif
    .write_reg_w(write_reg_w)
  );

  // Inputs change 1 ns after a rising edge. Combinational outputs are
  // checked 4 ns later, at the falling edge. Registered outputs are checked
  // 1 ns after the next rising edge.
  task automatic drive(input logic [2:0] c, input logic [31:0] a, input logic [31:0] wd,
                       input logic [4:0] wr, input logic ack, input logic [31:0] rd);
    control_m = c; alu_result_m = a; write_data_m = wd; write_reg_m = wr;
    dmem_ack = ack; dmem_rdata = rd;
  endtask

  task automatic next_edge();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(3'b000, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
    repeat (2) @(posedge clk);
    #4;
    n_checks++; if (control_w !== 2'b00) begin n_fail++; $display("FAIL reset_control_w got %h want 0", control_w); end
    n_checks++; if (alu_result_w !== 32'd0 || mem_read_data_w !== 32'd0 || write_reg_w !== 5'd0) begin
      n_fail++; $display("FAIL reset_w_regs got %h %h %h want 0", alu_result_w, mem_read_data_w, write_reg_w); end
    n_checks++; if (dmem_req !== 1'b0 || stall_m !== 1'b0) begin n_fail++; $display("FAIL reset_req_stall got %b%b want 00", dmem_req, stall_m); end
    reset = 1'b0;
    next_edge();
  endtask

  task automatic test_alu();
    drive(3'b100, 32'h10, 32'h0, 5'd5, 1'b0, 32'h0);
    #4;
    n_checks++; if (dmem_req !== 1'b0 || stall_m !== 1'b0) begin n_fail++; $display("FAIL alu_req_stall got %b%b want 00", dmem_req, stall_m); end
    next_edge();
    n_checks++; if (control_w !== 2'b10) begin n_fail++; $display("FAIL alu_control_w got %b want 10", control_w); end
    n_checks++; if (alu_result_w !== 32'h10 || write_reg_w !== 5'd5 || mem_read_data_w !== 32'd0) begin
      n_fail++; $display("FAIL alu_w_regs got %h %h %h want 10 05 0", alu_result_w, write_reg_w, mem_read_data_w); end
  endtask

  task automatic test_load_zero_wait();
    drive(3'b110, 32'h103, 32'h0, 5'd7, 1'b1, 32'hDEADBEEF);
    #4;
    n_checks++; if (dmem_addr !== 32'h100) begin n_fail++; $display("FAIL ld0_addr got %h want 00000100", dmem_addr); end
    n_checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || stall_m !== 1'b0) begin
      n_fail++; $display("FAIL ld0_req_we_stall got %b%b%b want 100", dmem_req, dmem_we, stall_m); end
    next_edge();
    n_checks++; if (control_w !== 2'b11 || mem_read_data_w !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL ld0_retire got %b %h want 11 deadbeef", control_w, mem_read_data_w); end
    n_checks++; if (alu_result_w !== 32'h103 || write_reg_w !== 5'd7) begin
      n_fail++; $display("FAIL ld0_w_regs got %h %h want 103 07", alu_result_w, write_reg_w); end
  endtask

  // Store acked on its fourth cycle. The W register held from the load above
  // has to survive the bubbles untouched.
  task automatic test_store_wait();
    drive(3'b001, 32'h200, 32'h12345678, 5'd0, 1'b0, 32'hFFFFFFFF);
    for (int i = 0; i < 3; i++) begin
      #4;
      n_checks++; if (stall_m !== 1'b1 || dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_wdata !== 32'h12345678) begin
        n_fail++; $display("FAIL st_wait%0d got stall=%b req=%b we=%b wdata=%h want 1 1 1 12345678", i, stall_m, dmem_req, dmem_we, dmem_wdata); end
      next_edge();
      n_checks++; if (control_w !== 2'b00 || alu_result_w !== 32'h103 || mem_read_data_w !== 32'hDEADBEEF) begin
        n_fail++; $display("FAIL st_bubble%0d got %b %h %h want 00 103 deadbeef", i, control_w, alu_result_w, mem_read_data_w); end
    end
    dmem_ack = 1'b1;
    #4;
    n_checks++; if (stall_m !== 1'b0 || dmem_req !== 1'b1) begin n_fail++; $display("FAIL st_ack_stall got %b%b want 01", stall_m, dmem_req); end
    next_edge();
    n_checks++; if (control_w !== 2'b00 || alu_result_w !== 32'h200 || mem_read_data_w !== 32'd0) begin
      n_fail++; $display("FAIL st_retire got %b %h %h want 00 200 0", control_w, alu_result_w, mem_read_data_w); end
    drive(3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    #4;
    n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL st_back_idle req got %b want 0", dmem_req); end
    next_edge();
  endtask

  task automatic test_store_priority();
    drive(3'b011, 32'h304, 32'hA5A5A5A5, 5'd2, 1'b1, 32'h11111111);
    #4;
    n_checks++; if (dmem_we !== 1'b1 || dmem_req !== 1'b1) begin n_fail++; $display("FAIL prio_we got %b%b want 11", dmem_we, dmem_req); end
    next_edge();
    n_checks++; if (control_w !== 2'b01 || mem_read_data_w !== 32'd0 || alu_result_w !== 32'h304) begin
      n_fail++; $display("FAIL prio_retire got %b %h %h want 01 0 304", control_w, mem_read_data_w, alu_result_w); end
  endtask

  task automatic test_ack_ignored();
    drive(3'b100, 32'h55, 32'h0, 5'd4, 1'b1, 32'h77777777);
    #4;
    n_checks++; if (dmem_req !== 1'b0 || stall_m !== 1'b0) begin n_fail++; $display("FAIL ign_req got %b%b want 00", dmem_req, stall_m); end
    next_edge();
    n_checks++; if (control_w !== 2'b10 || mem_read_data_w !== 32'd0) begin
      n_fail++; $display("FAIL ign_retire got %b %h want 10 0", control_w, mem_read_data_w); end
  endtask

  task automatic test_back_to_back();
    drive(3'b110, 32'h44, 32'h0, 5'd3, 1'b0, 32'h0);
    #4;
    n_checks++; if (stall_m !== 1'b1) begin n_fail++; $display("FAIL b2b_stall got %b want 1", stall_m); end
    next_edge();
    n_checks++; if (control_w !== 2'b00) begin n_fail++; $display("FAIL b2b_bubble got %b want 00", control_w); end
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
    #4;
    n_checks++; if (stall_m !== 1'b0) begin n_fail++; $display("FAIL b2b_release got %b want 0", stall_m); end
    next_edge();
    n_checks++; if (control_w !== 2'b11 || mem_read_data_w !== 32'hCAFEF00D || alu_result_w !== 32'h44 || write_reg_w !== 5'd3) begin
      n_fail++; $display("FAIL b2b_load got %b %h %h %h want 11 cafef00d 44 03", control_w, mem_read_data_w, alu_result_w, write_reg_w); end
    drive(3'b100, 32'h99, 32'h0, 5'd9, 1'b0, 32'h0);
    #4;
    n_checks++; if (dmem_req !== 1'b0 || stall_m !== 1'b0) begin n_fail++; $display("FAIL b2b_alu_req got %b%b want 00", dmem_req, stall_m); end
    next_edge();
    n_checks++; if (control_w !== 2'b10 || alu_result_w !== 32'h99 || write_reg_w !== 5'd9 || mem_read_data_w !== 32'd0) begin
      n_fail++; $display("FAIL b2b_alu got %b %h %h %h want 10 99 09 0", control_w, alu_result_w, write_reg_w, mem_read_data_w); end
    drive(3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    next_edge();
    n_checks++; if (control_w !== 2'b00) begin n_fail++; $display("FAIL b2b_no_dup got %b want 00", control_w); end
  endtask

  task automatic test_reset_mid_wait();
    drive(3'b110, 32'h80, 32'h0, 5'd6, 1'b0, 32'h0);
    next_edge();
    #2;
    n_checks++; if (dmem_req !== 1'b1 || stall_m !== 1'b1) begin n_fail++; $display("FAIL rmw_pre got %b%b want 11", dmem_req, stall_m); end
    reset = 1'b1;
    #1;
    n_checks++; if (dmem_req !== 1'b0 || stall_m !== 1'b0) begin n_fail++; $display("FAIL rmw_async got %b%b want 00", dmem_req, stall_m); end
    n_checks++; if (control_w !== 2'b00 || alu_result_w !== 32'd0 || mem_read_data_w !== 32'd0 || write_reg_w !== 5'd0) begin
      n_fail++; $display("FAIL rmw_w_regs got %b %h %h %h want 0", control_w, alu_result_w, mem_read_data_w, write_reg_w); end
    @(posedge clk); #3;
    reset = 1'b0;
    drive(3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    #1;
    n_checks++; if (dmem_req !== 1'b0 || stall_m !== 1'b0) begin n_fail++; $display("FAIL rmw_idle got %b%b want 00", dmem_req, stall_m); end
    next_edge();
  endtask

`ifdef DMEM_TIMEOUT_EN
  task automatic test_timeout(input logic ack_at_limit);
    drive(3'b110, 32'h120, 32'h0, 5'd8, 1'b0, 32'h3C3C3C3C);
    // One IDLE request cycle plus four WAIT cycles before the limit is hit.
    for (int i = 0; i < 5; i++) begin
      #4;
      n_checks++; if (stall_m !== 1'b1 || mem_fault !== 1'b0) begin
        n_fail++; $display("FAIL tmo_wait%0d got stall=%b fault=%b want 1 0", i, stall_m, mem_fault); end
      next_edge();
    end
    dmem_ack = ack_at_limit;
    #4;
    n_checks++; if (stall_m !== 1'b0 || mem_fault !== !ack_at_limit) begin
      n_fail++; $display("FAIL tmo_limit ack=%b got stall=%b fault=%b want 0 %b", ack_at_limit, stall_m, mem_fault, !ack_at_limit); end
    next_edge();
    n_checks++; if (control_w !== (ack_at_limit ? 2'b11 : 2'b00)) begin
      n_fail++; $display("FAIL tmo_control_w ack=%b got %b want %b", ack_at_limit, control_w, ack_at_limit ? 2'b11 : 2'b00); end
    drive(3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    #4;
    n_checks++; if (dmem_req !== 1'b0 || mem_fault !== 1'b0) begin
      n_fail++; $display("FAIL tmo_after got req=%b fault=%b want 0 0", dmem_req, mem_fault); end
    next_edge();
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_load_zero_wait();
    test_store_wait();
    test_store_priority();
    test_ack_ignored();
    test_back_to_back();
    test_alu();
    test_reset_mid_wait();
`ifdef DMEM_TIMEOUT_EN
    test_timeout(1'b0);
    test_timeout(1'b1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
